// File: rtl/agc_pkg.sv
// Shared types and constants for the peak-tracking AGC loop.
package agc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2,
    SETTLE  = 2'd3
  } agc_state_t;

  // Power-up gain byte: multiplier code 0, shift code 8 (unity).
  localparam logic [7:0] GAIN_CTRL_RESET = 8'h08;

  localparam logic [3:0] SHIFT_CODE_MIN = 4'd0;
  localparam logic [3:0] SHIFT_CODE_MAX = 4'd15;

  // Field positions inside the gain_control byte.
  localparam int MULT_MSB  = 7;
  localparam int MULT_LSB  = 4;
  localparam int SHIFT_MSB = 3;
  localparam int SHIFT_LSB = 0;

endpackage

// File: rtl/agc_abs_sat.sv
// Saturating magnitude: signed sample -> unsigned magnitude one bit narrower.
// The most-negative input has no positive twin, so it clips to all-ones.
module agc_abs_sat #(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic        [DATA_WIDTH-2:0] magnitude
);

  function automatic logic [DATA_WIDTH-2:0] abs_sat(input logic signed [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-2:0] neg;
    // For any negative x other than the minimum, |x| fits in the low bits of -x.
    neg = -x[DATA_WIDTH-2:0];
    if (!x[DATA_WIDTH-1]) begin
      return x[DATA_WIDTH-2:0];
    end else if (x[DATA_WIDTH-2:0] == '0) begin
      return '1;
    end else begin
      return neg;
    end
  endfunction

  assign magnitude = abs_sat(sample);

endmodule

// File: rtl/agc_peak_controller.sv
// Closed-loop AGC: measures windowed peak magnitude of the scaler output and
// nudges the shift nibble of gain_control to keep the peak between thresholds.
module agc_peak_controller
  import agc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int WINDOW_LEN     = 1024,
  parameter int HIGH_THRESH    = 2**(DATA_WIDTH-2),
  parameter int LOW_THRESH     = 2**(DATA_WIDTH-4),
  parameter int SETTLE_SAMPLES = 16,
  parameter int LOCK_WINDOWS   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid_in,
  input  logic                         agc_enable,
  input  logic        [7:0]            manual_gain_control,
  output logic        [7:0]            gain_control,
  output logic                         gain_update,
  output logic        [DATA_WIDTH-2:0] peak_out,
  output logic                         agc_locked
);

  localparam int WIN_W  = $clog2(WINDOW_LEN + 1);
  localparam int SET_W  = $clog2(SETTLE_SAMPLES + 1);
  localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [WIN_W-1:0]      WIN_LAST = WIN_W'(WINDOW_LEN - 1);
  localparam logic [SET_W-1:0]      SET_LAST = SET_W'(SETTLE_SAMPLES - 1);
  localparam logic [LOCK_W-1:0]     LOCK_SAT = LOCK_W'(LOCK_WINDOWS);
  localparam logic [DATA_WIDTH-2:0] HIGH_T   = (DATA_WIDTH-1)'(HIGH_THRESH);
  localparam logic [DATA_WIDTH-2:0] LOW_T    = (DATA_WIDTH-1)'(LOW_THRESH);

  agc_state_t            state, state_nxt;
  logic [WIN_W-1:0]      win_cnt, win_cnt_nxt;
  logic [SET_W-1:0]      set_cnt, set_cnt_nxt;
  logic [LOCK_W-1:0]     lock_cnt, lock_nxt;
  logic [DATA_WIDTH-2:0] peak, peak_nxt;
  logic [DATA_WIDTH-2:0] peak_out_nxt;
  logic [DATA_WIDTH-2:0] mag_p0;
  logic [3:0]            code, code_nxt;
  logic [7:0]            gain_nxt;
  logic                  locked_nxt;
  logic                  too_high, too_low;

  agc_abs_sat #(.DATA_WIDTH(DATA_WIDTH)) u_abs (
    .sample    (sample_in),
    .magnitude (mag_p0)
  );

  assign code     = gain_control[SHIFT_MSB:SHIFT_LSB];
  assign too_high = (peak > HIGH_T);
  assign too_low  = (peak < LOW_T);
  // Multiplier nibble always follows the manual setting one cycle later.
  assign gain_nxt = {manual_gain_control[MULT_MSB:MULT_LSB], code_nxt};

  // Next-state, window bookkeeping and shift-code decision.
  always_comb begin
    state_nxt    = state;
    win_cnt_nxt  = win_cnt;
    set_cnt_nxt  = set_cnt;
    lock_nxt     = lock_cnt;
    peak_nxt     = peak;
    peak_out_nxt = peak_out;
    code_nxt     = code;
    locked_nxt   = agc_locked;

    if (state != IDLE && !agc_enable) begin
      // Leaving closed loop drops any pending decision.
      state_nxt  = IDLE;
      lock_nxt   = '0;
      locked_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          code_nxt   = manual_gain_control[SHIFT_MSB:SHIFT_LSB];
          lock_nxt   = '0;
          locked_nxt = 1'b0;
          if (agc_enable) begin
            state_nxt   = MEASURE;
            win_cnt_nxt = '0;
            peak_nxt    = '0;
          end
        end
        MEASURE: begin
          if (sample_valid_in) begin
            peak_nxt    = (mag_p0 > peak) ? mag_p0 : peak;
            win_cnt_nxt = win_cnt + 1'b1;
            if (win_cnt == WIN_LAST) begin
              state_nxt = DECIDE;
            end
          end
        end
        DECIDE: begin
          peak_out_nxt = peak;
          peak_nxt     = '0;
          win_cnt_nxt  = '0;
          set_cnt_nxt  = '0;
          if (too_high && code != SHIFT_CODE_MIN) begin
            code_nxt   = code - 1'b1;
            lock_nxt   = '0;
            locked_nxt = 1'b0;
            state_nxt  = SETTLE;
          end else if (too_low && code != SHIFT_CODE_MAX) begin
            code_nxt   = code + 1'b1;
            lock_nxt   = '0;
            locked_nxt = 1'b0;
            state_nxt  = SETTLE;
          end else if (too_high || too_low) begin
            // Out of band but pinned at a code limit: not settled.
            lock_nxt   = '0;
            locked_nxt = 1'b0;
            state_nxt  = MEASURE;
          end else begin
            lock_nxt   = (lock_cnt == LOCK_SAT) ? lock_cnt : lock_cnt + 1'b1;
            locked_nxt = (lock_nxt >= LOCK_SAT);
            state_nxt  = MEASURE;
          end
        end
        SETTLE: begin
          if (sample_valid_in) begin
            if (set_cnt == SET_LAST) begin
              state_nxt   = MEASURE;
              peak_nxt    = '0;
              win_cnt_nxt = '0;
            end else begin
              set_cnt_nxt = set_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register update; gain_update flags the first cycle a new gain byte is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      win_cnt      <= '0;
      set_cnt      <= '0;
      lock_cnt     <= '0;
      peak         <= '0;
      peak_out     <= '0;
      gain_control <= GAIN_CTRL_RESET;
      gain_update  <= 1'b0;
      agc_locked   <= 1'b0;
    end else begin
      state        <= state_nxt;
      win_cnt      <= win_cnt_nxt;
      set_cnt      <= set_cnt_nxt;
      lock_cnt     <= lock_nxt;
      peak         <= peak_nxt;
      peak_out     <= peak_out_nxt;
      gain_control <= gain_nxt;
      gain_update  <= (gain_nxt != gain_control);
      agc_locked   <= locked_nxt;
    end
  end

endmodule

// File: doc/agc_peak_controller.md
Name: agc_peak_controller

Overview:
Closed-loop automatic gain controller that sits directly downstream of the adaptive gain/shift scaler. It consumes the scaler's output samples, measures peak magnitude over fixed windows, and steps the shift nibble of the 8-bit gain_control byte to keep the peak between two thresholds. The gain_control output feeds back to the scaler. When AGC is disabled, it passes the RP2040 manual setting through.

Parameters:
DATA_WIDTH, 32, sample width (signed two's complement)
WINDOW_LEN, 1024, valid samples per measurement window (>=2)
HIGH_THRESH, 2**(DATA_WIDTH-2), peak above this -> step shift code down (more right shift)
LOW_THRESH, 2**(DATA_WIDTH-4), peak below this -> step shift code up (less right shift / left shift)
SETTLE_SAMPLES, 16, valid samples discarded after a gain change (>=1)
LOCK_WINDOWS, 4, consecutive in-band windows before agc_locked asserts

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sample_in  in  DATA_WIDTH  scaler output sample, signed
sample_valid_in  in  1  sample_in qualifier
agc_enable  in  1  1 = closed loop, 0 = manual pass-through
manual_gain_control  in  8  RP2040 setting; [7:4] multiplier code, [3:0] shift code
gain_control  out  8  to scaler; [7:4] = manual multiplier, [3:0] = AGC/manual shift code
gain_update  out  1  one-cycle pulse in the first cycle that gain_control holds a new value
peak_out  out  DATA_WIDTH-1  unsigned peak magnitude of the last completed window
agc_locked  out  1  loop settled in band

Behaviour:
- Reset (clk edge with rst=1; this takes priority over all other inputs): gain_control=8'h08, gain_update=0, peak_out=0, agc_locked=0, counters=0, state=IDLE. Reset mid-window discards the partial window.
- Magnitude: |x| saturates, so the most-negative input maps to 2**(DATA_WIDTH-1)-1. The result is unsigned DATA_WIDTH-1 bits.
- gain_control[7:4] is registered from manual_gain_control[7:4] every cycle, in all states (1-cycle latency).
- States: IDLE, MEASURE, DECIDE, SETTLE.
- IDLE:
  - gain_control[3:0] is registered from manual_gain_control[3:0] every cycle.
  - agc_locked=0.
  - agc_enable=1 -> MEASURE next cycle. Window counter and peak are cleared, and the shift code starts from the current value.
- MEASURE:
  - Each valid sample updates peak = max(peak, |x|) and increments the window counter.
  - The cycle that accepts the WINDOW_LEN-th sample (cycle t) moves to DECIDE. That sample is included in the peak.
- DECIDE (cycle t+1):
  - peak_out <= peak.
  - peak > HIGH_THRESH and code > 0 -> code-1.
  - peak < LOW_THRESH and code < 15 -> code+1.
  - Otherwise hold. peak equal to either threshold is in-band.
  - Change -> new gain_control and gain_update=1 at t+2; lock counter cleared; agc_locked=0; -> SETTLE.
  - Hold, in band -> lock counter +1 (saturating). agc_locked=1 once count>=LOCK_WINDOWS. -> MEASURE.
  - Hold because the code is clamped at 0 or 15 -> lock counter cleared, agc_locked=0, no gain_update -> MEASURE.
  - Peak and window counter clear on leaving DECIDE.
  - sample_valid_in during DECIDE is ignored.
- SETTLE:
  - Counts SETTLE_SAMPLES valid samples and discards them (they do not feed the peak), then -> MEASURE with peak=0.
- agc_enable=0 in any non-IDLE state -> IDLE next cycle. A pending DECIDE result is discarded, agc_locked=0, and gain_control tracks manual one cycle later.
- gain_update pulses for any change of the gain_control register in any state, including manual changes and AGC exit. It is high in the first cycle the new value is visible and never for two consecutive cycles for one change.
- No backpressure: every sample_valid_in is consumed or discarded. Throughput is 1 sample/cycle.

Decomposition:
- Package agc_pkg:
  - state enum (IDLE, MEASURE, DECIDE, SETTLE)
  - GAIN_CTRL_RESET=8'h08
  - SHIFT_CODE_MIN=0, SHIFT_CODE_MAX=15
  - the gain_control field positions
- One combinational sub-module, agc_abs_sat: signed DATA_WIDTH in -> saturated unsigned DATA_WIDTH-1 magnitude. Everything else stays in one module.

Test Plan:
Parameters for all scenarios: DATA_WIDTH=16, WINDOW_LEN=8, HIGH=16384, LOW=4096, SETTLE=4, LOCK=2.
1. Release rst with agc_enable=0 and manual=8'h3A -> gain_control=8'h08 during reset, then 8'h3A one cycle after the first post-reset edge, with a single gain_update pulse.
2. agc_enable=1, code 8, one window of eight samples with max +20000 -> peak_out=20000 at t+2, gain_control[3:0]=7 and gain_update=1 at t+2. The next four valid samples of 30000 do not affect the following peak.
3. Windows with peak 1000 starting at code 14 -> 15, then at 15 no change, no pulse, agc_locked stays 0.
4. Window containing -32768 -> peak_out=32767, and the code decrements.
5. Three in-band windows (peak 8000) -> agc_locked=1 after the second DECIDE. A following window with peak 16385 clears agc_locked and decrements the code.
6. Drop agc_enable mid-SETTLE, then mid-MEASURE assert rst -> IDLE, manual value applied next cycle; rst returns all outputs to their reset values, and a fresh window needs eight new samples.
